// File: rtl/mcs51_timer_bank.sv
// 8051-style timer/counter bank: NUM_TIMERS channels with modes 0-3, gate control,
// synchronised external count/gate pins and per-channel overflow interrupts.
module mcs51_timer_bank #(
    parameter int NUM_TIMERS = 2,
    parameter int PRESCALE   = 12,
    parameter int CH_W       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sfr_wr,
    input  logic [CH_W-1:0]       sfr_ch,
    input  logic [1:0]            sfr_reg,
    input  logic [7:0]            sfr_wdata,
    output logic [7:0]            sfr_rdata,
    input  logic [NUM_TIMERS-1:0] t_pin,
    input  logic [NUM_TIMERS-1:0] int_pin,
    input  logic [NUM_TIMERS-1:0] int_ack,
    output logic [NUM_TIMERS-1:0] irq
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [CH_W:0]   NUM_L   = (CH_W + 1)'(NUM_TIMERS);

    logic [PS_W-1:0]         ps_r;
    logic                    tick_s;
    logic [NUM_TIMERS-1:0]   t_meta_r;
    logic [NUM_TIMERS-1:0]   t_sync_r;
    logic [NUM_TIMERS-1:0]   t_hist_r;
    logic [NUM_TIMERS-1:0]   i_meta_r;
    logic [NUM_TIMERS-1:0]   i_sync_r;
    logic [NUM_TIMERS-1:0]   t_fall_s;
    logic [NUM_TIMERS*8-1:0] tl_all_s;
    logic [NUM_TIMERS*8-1:0] th_all_s;
    logic [NUM_TIMERS*8-1:0] mode_all_s;
    logic [NUM_TIMERS*8-1:0] ctrl_all_s;
    logic [NUM_TIMERS*8-1:0] reg_vec_s;

    assign tick_s   = (ps_r == PS_LAST);
    assign t_fall_s = t_hist_r & ~t_sync_r;

    // Free-running machine-cycle prescaler shared by every channel
    always_ff @(posedge clk) begin
        if (reset) begin
            ps_r <= {PS_W{1'b0}};
        end else if (tick_s) begin
            ps_r <= {PS_W{1'b0}};
        end else begin
            ps_r <= ps_r + PS_W'(1'b1);
        end
    end

    // Pin synchronisers; idle-high so no spurious fall is seen after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            t_meta_r <= {NUM_TIMERS{1'b1}};
            t_sync_r <= {NUM_TIMERS{1'b1}};
            t_hist_r <= {NUM_TIMERS{1'b1}};
            i_meta_r <= {NUM_TIMERS{1'b1}};
            i_sync_r <= {NUM_TIMERS{1'b1}};
        end else begin
            t_meta_r <= t_pin;
            t_sync_r <= t_meta_r;
            t_hist_r <= t_sync_r;
            i_meta_r <= int_pin;
            i_sync_r <= i_meta_r;
        end
    end

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        logic [7:0]  tl_r;
        logic [7:0]  th_r;
        logic [3:0]  mode_r;
        logic        tr_r;
        logic        tf_r;
        logic        tf2_r;
        logic        sel_s;
        logic        wr_tl_s;
        logic        wr_th_s;
        logic        wr_mode_s;
        logic        wr_ctrl_s;
        logic        run_s;
        logic        inc_s;
        logic        th_inc_s;
        logic        tl_ovf_s;
        logic        th_ovf_s;
        logic        tf_nxt_s;
        logic        tf2_nxt_s;
        logic [7:0]  tl_cnt_s;
        logic [7:0]  th_cnt_s;
        logic [12:0] c13_s;
        logic [15:0] c16_s;

        assign sel_s     = sfr_wr & (sfr_ch == CH_W'(i));
        assign wr_tl_s   = sel_s & (sfr_reg == 2'd0);
        assign wr_th_s   = sel_s & (sfr_reg == 2'd1);
        assign wr_mode_s = sel_s & (sfr_reg == 2'd2);
        assign wr_ctrl_s = sel_s & (sfr_reg == 2'd3);

        // Counting per mode; a software write to a half cancels that cycle's increment
        always_comb begin
            run_s    = tr_r & (~mode_r[3] | i_sync_r[i]);
            inc_s    = run_s & (mode_r[2] ? t_fall_s[i] : tick_s);
            th_inc_s = run_s & tick_s;
            c13_s    = {th_r, tl_r[4:0]} + 13'd1;
            c16_s    = {th_r, tl_r} + 16'd1;
            tl_cnt_s = tl_r;
            th_cnt_s = th_r;
            tl_ovf_s = 1'b0;
            th_ovf_s = 1'b0;
            case (mode_r[1:0])
                2'd0: begin
                    if (inc_s & ~wr_tl_s & ~wr_th_s) begin
                        tl_cnt_s = {tl_r[7:5], c13_s[4:0]};
                        th_cnt_s = c13_s[12:5];
                        tl_ovf_s = (c13_s == 13'd0);
                    end else begin
                        tl_ovf_s = 1'b0;
                    end
                end
                2'd1: begin
                    if (inc_s & ~wr_tl_s & ~wr_th_s) begin
                        tl_cnt_s = c16_s[7:0];
                        th_cnt_s = c16_s[15:8];
                        tl_ovf_s = (c16_s == 16'd0);
                    end else begin
                        tl_ovf_s = 1'b0;
                    end
                end
                2'd2: begin
                    if (inc_s & ~wr_tl_s & (tl_r == 8'hFF)) begin
                        tl_cnt_s = th_r;
                        tl_ovf_s = 1'b1;
                    end else if (inc_s & ~wr_tl_s) begin
                        tl_cnt_s = tl_r + 8'd1;
                    end else begin
                        tl_cnt_s = tl_r;
                    end
                end
                2'd3: begin
                    if (inc_s & ~wr_tl_s) begin
                        tl_cnt_s = tl_r + 8'd1;
                        tl_ovf_s = (tl_r == 8'hFF);
                    end else begin
                        tl_cnt_s = tl_r;
                    end
                    if (th_inc_s & ~wr_th_s) begin
                        th_cnt_s = th_r + 8'd1;
                        th_ovf_s = (th_r == 8'hFF);
                    end else begin
                        th_cnt_s = th_r;
                    end
                end
                default: begin
                    tl_cnt_s = tl_r;
                    th_cnt_s = th_r;
                end
            endcase
        end

        // Flag priority: hardware overflow, then acknowledge, then software write
        always_comb begin
            if (tl_ovf_s) begin
                tf_nxt_s = 1'b1;
            end else if (int_ack[i]) begin
                tf_nxt_s = 1'b0;
            end else if (wr_ctrl_s) begin
                tf_nxt_s = sfr_wdata[1];
            end else begin
                tf_nxt_s = tf_r;
            end
            if (th_ovf_s) begin
                tf2_nxt_s = 1'b1;
            end else if (int_ack[i]) begin
                tf2_nxt_s = 1'b0;
            end else if (wr_ctrl_s) begin
                tf2_nxt_s = sfr_wdata[2];
            end else begin
                tf2_nxt_s = tf2_r;
            end
        end

        // Channel state registers
        always_ff @(posedge clk) begin
            if (reset) begin
                tl_r   <= 8'h00;
                th_r   <= 8'h00;
                mode_r <= 4'h0;
                tr_r   <= 1'b0;
                tf_r   <= 1'b0;
                tf2_r  <= 1'b0;
            end else begin
                tl_r  <= wr_tl_s ? sfr_wdata : tl_cnt_s;
                th_r  <= wr_th_s ? sfr_wdata : th_cnt_s;
                tf_r  <= tf_nxt_s;
                tf2_r <= tf2_nxt_s;
                if (wr_mode_s) begin
                    mode_r <= sfr_wdata[3:0];
                end
                if (wr_ctrl_s) begin
                    tr_r <= sfr_wdata[0];
                end
            end
        end

        assign tl_all_s[i*8 +: 8]   = tl_r;
        assign th_all_s[i*8 +: 8]   = th_r;
        assign mode_all_s[i*8 +: 8] = {4'h0, mode_r};
        assign ctrl_all_s[i*8 +: 8] = {5'b00000, tf2_r, tf_r, tr_r};
        assign irq[i]               = tf_r | tf2_r;
    end

    // Register read-back; unimplemented channels read as zero
    always_comb begin
        case (sfr_reg)
            2'd0:    reg_vec_s = tl_all_s;
            2'd1:    reg_vec_s = th_all_s;
            2'd2:    reg_vec_s = mode_all_s;
            2'd3:    reg_vec_s = ctrl_all_s;
            default: reg_vec_s = tl_all_s;
        endcase
        if ({1'b0, sfr_ch} < NUM_L) begin
            sfr_rdata = 8'(reg_vec_s >> {sfr_ch, 3'b000});
        end else begin
            sfr_rdata = 8'h00;
        end
    end

endmodule
